// File: rtl/fsm_onehot_guarded_if.sv
// ---------------------------------------------------------------------------
// fsm_onehot_guarded_if
// Bundles the control requests and status outputs of fsm_onehot_guarded.
//   master : drives advance/back/clear_fault/inject_en/inject_val and
//            observes state/state_idx/legal/timeout/fault/illegal_cnt
//   slave  : the sequencer side (the reverse directions)
// clk and resetn stay outside the interface as plain module ports.
// ---------------------------------------------------------------------------
interface fsm_onehot_guarded_if #(
  parameter int N_STATES = 4
) ();
  localparam int IDX_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;

  logic                advance;
  logic                back;
  logic                clear_fault;
  logic                inject_en;
  logic [N_STATES-1:0] inject_val;
  logic [N_STATES-1:0] state;
  logic [IDX_W-1:0]    state_idx;
  logic                legal;
  logic                timeout;
  logic                fault;
  logic [7:0]          illegal_cnt;

  modport master (
    output advance, back, clear_fault, inject_en, inject_val,
    input  state, state_idx, legal, timeout, fault, illegal_cnt
  );

  modport slave (
    input  advance, back, clear_fault, inject_en, inject_val,
    output state, state_idx, legal, timeout, fault, illegal_cnt
  );
endinterface

// File: rtl/fsm_onehot_guarded.sv
// ---------------------------------------------------------------------------
// fsm_onehot_guarded
// Hardened one-hot sequencer: every encoding is reachable, illegal encodings
// (all-zero or multi-hot) are recovered to state 0 in one cycle, a per-state
// dwell watchdog forces state 0 after TIMEOUT cycles, and a sticky fault
// locks out advance until cleared.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   bus     : slave side of fsm_onehot_guarded_if
//             in : advance, back, clear_fault, inject_en, inject_val
//             out: state (reg), state_idx/legal (comb), timeout (reg pulse),
//                  fault (reg, sticky), illegal_cnt (reg, saturating)
// ---------------------------------------------------------------------------
module fsm_onehot_guarded #(
  parameter int N_STATES = 4,
  parameter int TIMEOUT  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  fsm_onehot_guarded_if.slave    bus
);
  localparam int IDX_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;
  localparam int DW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [N_STATES-1:0] ONE = {{(N_STATES-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DWELL_MAX = DW'(TIMEOUT - 1);

  // Which rule decided the next state this cycle (highest priority wins).
  typedef enum logic [2:0] {
    C_HOLD, C_INJECT, C_RECOVER, C_BACK, C_WATCHDOG, C_ADVANCE
  } cause_e;

  logic [N_STATES-1:0] state_q, state_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic                timeout_q, timeout_d;
  logic                fault_q, fault_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                legal_c;
  logic [IDX_W-1:0]    idx_c;
  cause_e              cause_c;

  assign legal_c = $onehot(state_q);

  always_comb begin
    idx_c = '0;
    if (legal_c) begin
      for (int i = 0; i < N_STATES; i++) begin
        if (state_q[i]) idx_c = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ONE;
      dwell_q   <= '0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    fault_d   = fault_q & ~bus.clear_fault;
    cnt_d     = cnt_q;
    cause_c   = C_HOLD;

    if (bus.inject_en) begin
      cause_c = C_INJECT;
    end else if (!legal_c) begin
      cause_c = C_RECOVER;
    end else if (bus.back) begin
      cause_c = C_BACK;
    end else if ((state_q != ONE) && (dwell_q == DWELL_MAX)) begin
      cause_c = C_WATCHDOG;
    end else if (bus.advance && !fault_q) begin
      cause_c = C_ADVANCE;
    end

    case (cause_c)
      C_INJECT: begin
        // Injection freezes the bookkeeping registers; only the raw vector moves.
        state_d = bus.inject_val;
        fault_d = fault_q;
      end
      C_RECOVER: begin
        // Setting fault here overrides a simultaneous clear_fault.
        state_d = ONE;
        fault_d = 1'b1;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end
      C_BACK: begin
        state_d = ONE;
      end
      C_WATCHDOG: begin
        state_d   = ONE;
        timeout_d = 1'b1;
      end
      C_ADVANCE: begin
        state_d = {state_q[N_STATES-2:0], state_q[N_STATES-1]};
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Dwell counts cycles spent in the current non-zero state; it restarts on
    // any change so a freshly entered state gets the full TIMEOUT window.
    if (cause_c == C_INJECT || cause_c == C_RECOVER ||
        state_d != state_q || state_q == ONE) begin
      dwell_d = '0;
    end else if (dwell_q == DWELL_MAX) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.state_idx   = idx_c;
  assign bus.legal       = legal_c;
  assign bus.timeout     = timeout_q;
  assign bus.fault       = fault_q;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_fsm_onehot_guarded.sv
// ---------------------------------------------------------------------------
// tb_fsm_onehot_guarded
// Directed bench for fsm_onehot_guarded (N_STATES=4, TIMEOUT=8). Each step
// pushes its expected outputs to a queue, clocks the DUT, then pops and
// compares against what the DUT shows one cycle later.
// ---------------------------------------------------------------------------
module tb_fsm_onehot_guarded;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fsm_onehot_guarded_if #(.N_STATES(4)) bus ();

  fsm_onehot_guarded #(.N_STATES(4), .TIMEOUT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic       to;
    logic       flt;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] st, input logic to,
                      input logic flt, input int cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.to = to; e.flt = flt; e.cnt = 8'(cnt);
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and checks every output against it.
  task automatic check_now();
    exp_t e;
    logic exp_legal;
    logic [1:0] exp_idx;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    exp_legal = (e.st == 4'b0001) || (e.st == 4'b0010) ||
                (e.st == 4'b0100) || (e.st == 4'b1000);
    case (e.st)
      4'b0010: exp_idx = 2'd1;
      4'b0100: exp_idx = 2'd2;
      4'b1000: exp_idx = 2'd3;
      default: exp_idx = 2'd0;
    endcase
    chk({e.tag, ".state"},   32'(bus.state),       32'(e.st));
    chk({e.tag, ".legal"},   32'(bus.legal),       32'(exp_legal));
    chk({e.tag, ".idx"},     32'(bus.state_idx),   32'(exp_idx));
    chk({e.tag, ".timeout"}, 32'(bus.timeout),     32'(e.to));
    chk({e.tag, ".fault"},   32'(bus.fault),       32'(e.flt));
    chk({e.tag, ".cnt"},     32'(bus.illegal_cnt), 32'(e.cnt));
  endtask

  // One clocked step: drive inputs, record expectation, clock, compare.
  task automatic cyc(input string tag, input bit adv, input bit bk, input bit clr,
                     input bit ie, input logic [3:0] iv,
                     input logic [3:0] est, input logic eto, input logic eflt,
                     input int ecnt);
    bus.advance     = adv;
    bus.back        = bk;
    bus.clear_fault = clr;
    bus.inject_en   = ie;
    bus.inject_val  = iv;
    push(tag, est, eto, eflt, ecnt);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    int c;
    bus.advance = 1'b0; bus.back = 1'b0; bus.clear_fault = 1'b0;
    bus.inject_en = 1'b0; bus.inject_val = 4'b0000;

    // Reset values
    #12;
    push("reset", 4'b0001, 1'b0, 1'b0, 0);
    check_now();
    $display("step reset: state=%b", bus.state);
    @(negedge clk);
    resetn = 1'b1;

    // Advance held five cycles, including the wrap 8 -> 1
    cyc("adv1", 1, 0, 0, 0, 4'b0, 4'b0010, 0, 0, 0);
    cyc("adv2", 1, 0, 0, 0, 4'b0, 4'b0100, 0, 0, 0);
    cyc("adv3", 1, 0, 0, 0, 4'b0, 4'b1000, 0, 0, 0);
    cyc("wrap", 1, 0, 0, 0, 4'b0, 4'b0001, 0, 0, 0);
    cyc("adv5", 1, 0, 0, 0, 4'b0, 4'b0010, 0, 0, 0);
    $display("step advance: state=%b", bus.state);

    // Watchdog: 0010 visible 8 cycles total, then forced to 0001 with pulse
    for (int i = 0; i < 7; i++) cyc("dwell", 0, 0, 0, 0, 4'b0, 4'b0010, 0, 0, 0);
    cyc("wdog",      0, 0, 0, 0, 4'b0, 4'b0001, 1, 0, 0);
    cyc("wdog_post", 0, 0, 0, 0, 4'b0, 4'b0001, 0, 0, 0);
    $display("step watchdog: state=%b timeout=%b", bus.state, bus.timeout);

    // Multi-hot injection, then one-cycle recovery
    cyc("inj0110", 0, 0, 0, 1, 4'b0110, 4'b0110, 0, 0, 0);
    cyc("recov1",  0, 0, 0, 0, 4'b0,    4'b0001, 0, 1, 1);
    $display("step inject: fault=%b cnt=%0d", bus.fault, bus.illegal_cnt);

    // Fault lockout, clear, resume
    cyc("lock1", 1, 0, 0, 0, 4'b0, 4'b0001, 0, 1, 1);
    cyc("lock2", 1, 0, 0, 0, 4'b0, 4'b0001, 0, 1, 1);
    cyc("clear", 1, 0, 1, 0, 4'b0, 4'b0001, 0, 0, 1);
    cyc("res1",  1, 0, 0, 0, 4'b0, 4'b0010, 0, 0, 1);
    cyc("res2",  1, 0, 0, 0, 4'b0, 4'b0100, 0, 0, 1);
    $display("step clear: state=%b fault=%b", bus.state, bus.fault);

    // advance and back together in state 0100: back wins
    cyc("advback", 1, 1, 0, 0, 4'b0, 4'b0001, 0, 0, 1);

    // Zero injection with clear_fault in the recovery cycle: set wins
    cyc("inj0000", 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1);
    cyc("setwins", 0, 0, 1, 0, 4'b0,    4'b0001, 0, 1, 2);
    // Remaining 259 injections drive illegal_cnt into saturation
    for (int i = 2; i <= 260; i++) begin
      c = (i > 255) ? 255 : i;
      cyc("injsat", 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, c);
      c = (i + 1 > 255) ? 255 : i + 1;
      cyc("recsat", 0, 0, 0, 0, 4'b0,    4'b0001, 0, 1, c);
    end
    $display("step saturate: cnt=%0d", bus.illegal_cnt);

    // Async reset mid-sequence, no clock edge in between
    cyc("clr2", 0, 0, 1, 0, 4'b0, 4'b0001, 0, 0, 255);
    cyc("pre",  1, 0, 0, 0, 4'b0, 4'b0010, 0, 0, 255);
    #1;
    resetn = 1'b0;
    #1;
    push("async_rst", 4'b0001, 1'b0, 1'b0, 0);
    check_now();
    $display("step async reset: state=%b cnt=%0d", bus.state, bus.illegal_cnt);
    @(negedge clk);
    resetn = 1'b1;
    cyc("post", 1, 0, 0, 0, 4'b0, 4'b0010, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
